inst_mem: RTL and testbench

Instruction memory that answers the core's fetch port (`rom_ce`, `rom_addr`, `rom_data`) and owns the program image. A byte-serial load port fills the memory with a valid/ready handshake. The block holds the core in reset until a complete image is loaded, then releases it. It sits beside `martianmips` at the SoC/testbench top level.

---
 rtl/inst_mem_pkg.sv | 13 +
 rtl/inst_mem_byte_packer.sv | 53 +++++
 rtl/inst_mem.sv | 115 +++++++++++
 tb/tb_inst_mem.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/inst_mem_pkg.sv
// Shared definitions for the instruction memory: FSM encoding, NOP word and default depth.
package inst_mem_defs;

    localparam int          DEPTH_LOG2_DEF = 10;
    localparam logic [31:0] NOP_WORD       = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_LOAD = 2'd0,
        ST_RUN  = 2'd1,
        ST_ERR  = 2'd2
    } state_e;

endpackage

// File: rtl/inst_mem_byte_packer.sv
// Packs a big-endian byte stream into 32-bit words; emits a word on the 4th byte
// or early on the last byte, with unfilled low bytes left as zero.
module byte_packer (
    input  logic        clk,
    input  logic        rst,
    input  logic        clear_i,
    input  logic        accept_i,
    input  logic [7:0]  byte_i,
    input  logic        last_i,
    output logic        word_valid_o,
    output logic [31:0] word_o
);

    logic [1:0]  cnt_q, cnt_d;
    logic [31:0] asm_q, asm_d;
    logic [31:0] merged;

    // Byte lane gi (gi=0 is [31:24]) takes the incoming byte when it is the current slot.
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        assign merged[31-8*gi -: 8] = (cnt_q == 2'(gi)) ? byte_i : asm_q[31-8*gi -: 8];
    end

    assign word_valid_o = accept_i && ((cnt_q == 2'd3) || last_i);
    assign word_o       = merged;

    always_comb begin
        cnt_d = cnt_q;
        asm_d = asm_q;
        if (clear_i) begin
            cnt_d = 2'd0;
            asm_d = '0;
        end else if (accept_i) begin
            if (word_valid_o) begin
                cnt_d = 2'd0;
                asm_d = '0;
            end else begin
                cnt_d = cnt_q + 2'd1;
                asm_d = merged;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= 2'd0;
            asm_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            asm_q <= asm_d;
        end
    end

endmodule

// File: rtl/inst_mem.sv
// Instruction memory with byte-serial image loader; holds the core in reset until
// a complete image is loaded and serves zero-latency fetches from the loaded words.
module inst_mem
    import inst_mem_defs::*;
#(
    parameter int DEPTH_LOG2 = DEPTH_LOG2_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rom_ce_i,
    input  logic [31:0] rom_addr_i,
    output logic [31:0] rom_data_o,
    input  logic        ld_valid_i,
    output logic        ld_ready_o,
    input  logic [7:0]  ld_byte_i,
    input  logic        ld_last_i,
    input  logic        ld_restart_i,
    output logic        core_rst_o,
    output logic        ld_done_o,
    output logic        ld_err_o
);

    localparam int                  DEPTH     = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] CAPACITY  = (DEPTH_LOG2+1)'(DEPTH);
    localparam logic [DEPTH_LOG2:0] COUNT_ONE = (DEPTH_LOG2+1)'(1);

    logic [31:0] mem [DEPTH];

    state_e                state_q, state_d;
    logic [DEPTH_LOG2-1:0] wptr_q, wptr_d;
    logic [DEPTH_LOG2:0]   wcount_q, wcount_d;

    logic        accept;
    logic        pk_valid;
    logic [31:0] pk_word;
    logic        full;
    logic        mem_we;

    // Restart takes priority over a byte offered in the same cycle.
    assign accept = ld_valid_i && ld_ready_o && !ld_restart_i;
    assign full   = (wcount_q == CAPACITY);
    assign mem_we = pk_valid && !full;

    byte_packer u_packer (
        .clk          (clk),
        .rst          (rst),
        .clear_i      (ld_restart_i),
        .accept_i     (accept),
        .byte_i       (ld_byte_i),
        .last_i       (ld_last_i),
        .word_valid_o (pk_valid),
        .word_o       (pk_word)
    );

    assign ld_ready_o = (state_q == ST_LOAD);
    assign core_rst_o = (state_q != ST_RUN);
    assign ld_done_o  = (state_q == ST_RUN);
    assign ld_err_o   = (state_q == ST_ERR);

    always_comb begin
        state_d  = state_q;
        wptr_d   = wptr_q;
        wcount_d = wcount_q;
        case (state_q)
            ST_LOAD: begin
                if (pk_valid) begin
                    if (full) begin
                        state_d = ST_ERR;
                    end else begin
                        wptr_d   = wptr_q + 1'b1;
                        wcount_d = wcount_q + COUNT_ONE;
                        if (ld_last_i) state_d = ST_RUN;
                    end
                end
            end
            ST_RUN:  state_d = ST_RUN;
            ST_ERR:  state_d = ST_ERR;
            default: state_d = ST_LOAD;
        endcase
        if (ld_restart_i) begin
            state_d  = ST_LOAD;
            wptr_d   = '0;
            wcount_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_LOAD;
            wptr_q   <= '0;
            wcount_q <= '0;
        end else begin
            state_q  <= state_d;
            wptr_q   <= wptr_d;
            wcount_q <= wcount_d;
        end
    end

    // Array is deliberately unreset; wcount masks anything stale.
    always_ff @(posedge clk) begin
        if (mem_we) mem[wptr_q] <= pk_word;
    end

    logic [DEPTH_LOG2-1:0]  rd_idx;
    logic [31-DEPTH_LOG2-2:0] rd_high;
    logic                   rom_addr_unused;

    assign rd_idx          = rom_addr_i[DEPTH_LOG2+1:2];
    assign rd_high         = rom_addr_i[31:DEPTH_LOG2+2];
    assign rom_addr_unused = ^rom_addr_i[1:0];

    assign rom_data_o = (rom_ce_i && (rd_high == '0) && ({1'b0, rd_idx} < wcount_q))
                        ? mem[rd_idx] : NOP_WORD;

endmodule

// File: tb/tb_inst_mem.sv
// Directed bench for inst_mem: a default-depth instance and a 4-word instance share stimulus.
module tb_inst_mem;

    logic        clk;
    logic        rst;
    logic        rom_ce;
    logic [31:0] rom_addr;
    logic        ld_valid;
    logic [7:0]  ld_byte;
    logic        ld_last;
    logic        ld_restart;

    logic [31:0] rom_data_a, rom_data_b;
    logic        ready_a, ready_b;
    logic        core_rst_a, core_rst_b;
    logic        done_a, done_b;
    logic        err_a, err_b;

    int total = 0;
    int bad   = 0;

    inst_mem dut_a (
        .clk          (clk),
        .rst          (rst),
        .rom_ce_i     (rom_ce),
        .rom_addr_i   (rom_addr),
        .rom_data_o   (rom_data_a),
        .ld_valid_i   (ld_valid),
        .ld_ready_o   (ready_a),
        .ld_byte_i    (ld_byte),
        .ld_last_i    (ld_last),
        .ld_restart_i (ld_restart),
        .core_rst_o   (core_rst_a),
        .ld_done_o    (done_a),
        .ld_err_o     (err_a)
    );

    inst_mem #(.DEPTH_LOG2(2)) dut_b (
        .clk          (clk),
        .rst          (rst),
        .rom_ce_i     (rom_ce),
        .rom_addr_i   (rom_addr),
        .rom_data_o   (rom_data_b),
        .ld_valid_i   (ld_valid),
        .ld_ready_o   (ready_b),
        .ld_byte_i    (ld_byte),
        .ld_last_i    (ld_last),
        .ld_restart_i (ld_restart),
        .core_rst_o   (core_rst_b),
        .ld_done_o    (done_b),
        .ld_err_o     (err_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
        $display("check %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic send(input logic [7:0] b, input logic last);
        @(negedge clk);
        ld_valid = 1'b1;
        ld_byte  = b;
        ld_last  = last;
        @(posedge clk);
        #1;
        ld_valid = 1'b0;
        ld_last  = 1'b0;
    endtask

    task automatic gap();
        @(negedge clk);
        ld_valid = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic restart();
        @(negedge clk);
        ld_restart = 1'b1;
        @(posedge clk);
        #1;
        ld_restart = 1'b0;
    endtask

    task automatic rd_a(input string tag, input logic [31:0] addr, input logic [31:0] exp);
        rom_ce   = 1'b1;
        rom_addr = addr;
        #1;
        check(tag, rom_data_a, exp);
    endtask

    task automatic rd_b(input string tag, input logic [31:0] addr, input logic [31:0] exp);
        rom_ce   = 1'b1;
        rom_addr = addr;
        #1;
        check(tag, rom_data_b, exp);
    endtask

    initial begin
        rst        = 1'b0;
        rom_ce     = 1'b1;
        rom_addr   = 32'h0;
        ld_valid   = 1'b0;
        ld_byte    = 8'h00;
        ld_last    = 1'b0;
        ld_restart = 1'b0;

        // Reset values
        #2;
        check("rst_ready",    32'(ready_a),    32'd1);
        check("rst_core_rst", 32'(core_rst_a), 32'd1);
        check("rst_done",     32'(done_a),     32'd0);
        check("rst_err",      32'(err_a),      32'd0);
        rd_a("rst_data", 32'h0, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;

        // Two-word image
        send(8'h24, 1'b0); send(8'h02, 1'b0); send(8'h00, 1'b0); send(8'h05, 1'b0);
        rd_a("t1_w0_early", 32'h0, 32'h24020005);
        check("t1_core_rst_loading", 32'(core_rst_a), 32'd1);
        send(8'h34, 1'b0); send(8'h03, 1'b0); send(8'h00, 1'b0);
        check("t1_done_before_last", 32'(done_a), 32'd0);
        send(8'h0A, 1'b1);
        check("t1_core_rst", 32'(core_rst_a), 32'd0);
        check("t1_done",     32'(done_a),     32'd1);
        check("t1_ready",    32'(ready_a),    32'd0);
        rd_a("t1_w0", 32'h0, 32'h24020005);
        rd_a("t1_w1", 32'h4, 32'h3403000A);
        rd_a("t1_addr5", 32'h5, 32'h3403000A);
        rd_a("t1_beyond", 32'h8, 32'h0);
        rd_a("t1_high_bit", 32'h0000_1000, 32'h0);
        rom_ce = 1'b0;
        #1;
        check("t1_ce_off", rom_data_a, 32'h0);

        // Partial last word is zero-padded
        restart();
        check("t2_ready_after_restart", 32'(ready_a), 32'd1);
        rd_a("t2_hidden", 32'h0, 32'h0);
        send(8'h11, 1'b0); send(8'h22, 1'b0); send(8'h33, 1'b0);
        send(8'h44, 1'b0); send(8'h55, 1'b0); send(8'h66, 1'b1);
        rd_a("t2_w0", 32'h0, 32'h11223344);
        rd_a("t2_w1", 32'h4, 32'h55660000);
        rd_a("t2_w2", 32'h8, 32'h0);
        check("t2_done", 32'(done_a), 32'd1);

        // Overflow on the 4-word instance
        restart();
        for (int i = 1; i <= 16; i++) send(8'(i), 1'b0);
        check("t3_err_pre", 32'(err_b), 32'd0);
        send(8'd17, 1'b1);
        check("t3_err",      32'(err_b),      32'd1);
        check("t3_core_rst", 32'(core_rst_b), 32'd1);
        check("t3_ready",    32'(ready_b),    32'd0);
        check("t3_done",     32'(done_b),     32'd0);
        rd_b("t3_w0", 32'h0, 32'h01020304);
        rd_b("t3_w1", 32'h4, 32'h05060708);
        rd_b("t3_w2", 32'h8, 32'h090A0B0C);
        rd_b("t3_w3", 32'hC, 32'h0D0E0F10);
        rd_b("t3_out_of_range", 32'h10, 32'h0);
        gap();
        check("t3_err_sticky", 32'(err_b), 32'd1);
        restart();
        check("t3_err_cleared", 32'(err_b),   32'd0);
        check("t3_ready_back",  32'(ready_b), 32'd1);
        rd_b("t3_r_w0", 32'h0, 32'h0);
        rd_b("t3_r_w1", 32'h4, 32'h0);
        rd_b("t3_r_w2", 32'h8, 32'h0);
        rd_b("t3_r_w3", 32'hC, 32'h0);

        // Gapped loading and restart colliding with a valid byte
        send(8'hAA, 1'b0); gap(); send(8'hBB, 1'b0); gap(); gap();
        @(negedge clk);
        ld_valid   = 1'b1;
        ld_byte    = 8'hCC;
        ld_restart = 1'b1;
        @(posedge clk);
        #1;
        ld_valid   = 1'b0;
        ld_restart = 1'b0;
        rd_a("t4_after_restart", 32'h0, 32'h0);
        send(8'h01, 1'b0); gap(); send(8'h02, 1'b0); send(8'h03, 1'b0); gap(); send(8'h04, 1'b0);
        rd_a("t4_w0", 32'h0, 32'h01020304);
        rd_a("t4_w1", 32'h4, 32'h0);
        check("t4_still_loading", 32'(core_rst_a), 32'd1);

        // Asynchronous reset in the middle of a load
        restart();
        send(8'hDE, 1'b0); send(8'hAD, 1'b0); send(8'hBE, 1'b0); send(8'hEF, 1'b0);
        send(8'h99, 1'b0); send(8'h88, 1'b0); send(8'h77, 1'b0);
        @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        check("t5_ready",    32'(ready_a),    32'd1);
        check("t5_core_rst", 32'(core_rst_a), 32'd1);
        check("t5_done",     32'(done_a),     32'd0);
        check("t5_err",      32'(err_a),      32'd0);
        rd_a("t5_data", 32'h0, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        send(8'h12, 1'b0); send(8'h34, 1'b0); send(8'h56, 1'b0); send(8'h78, 1'b1);
        rd_a("t5_w0", 32'h0, 32'h12345678);
        rd_a("t5_w1", 32'h4, 32'h0);
        check("t5_done_reload", 32'(done_a), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
